// File: rtl/lc3_datapath_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_datapath_gen
//  Brief    : Parametrised LC-3 datapath (regfile, PC, IR, MAR/MDR, ALU,
//             EAB, N/Z/P) on a single muxed internal bus, with a req/ack
//             memory port (wait-state FSM + timeout) and bus-contention flag.
//  Revision : 1.0 - initial release
// ============================================================================
module lc3_datapath_gen #(
  parameter int  DATA_W      = 16,
  parameter int  NREG        = 8,
  parameter int  MEM_TIMEOUT = 255,
  localparam int RA_W        = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_mdr,
  input  logic              ena_pc,
  input  logic              ena_alu,
  input  logic              ena_marm,
  input  logic              ld_pc,
  input  logic              ld_ir,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              reg_we,
  input  logic              flag_we,
  input  logic              sel_mar,
  input  logic              sel_eab1,
  input  logic [1:0]        sel_pc,
  input  logic [1:0]        sel_eab2,
  input  logic [1:0]        alu_ctrl,
  input  logic [RA_W-1:0]   sr1,
  input  logic [RA_W-1:0]   sr2,
  input  logic [RA_W-1:0]   dr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              bus_err,
  output logic              n,
  output logic              z,
  output logic              p,
  output logic [DATA_W-1:0] ir
);

  // Timeout counter only needs to reach MEM_TIMEOUT-1; abort fires on the
  // edge that would take it to MEM_TIMEOUT.
  localparam int                  C_TCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [C_TCNT_W-1:0] C_TLAST  = C_TCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  // Architectural state
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_n;
  logic                r_z;
  logic                r_p;
  logic                r_bus_err;

  // Memory FSM state
  mem_state_t          r_state;
  mem_state_t          w_state_nxt;
  logic                r_is_wr;
  logic                w_is_wr_nxt;
  logic [C_TCNT_W-1:0] r_tcnt;
  logic [C_TCNT_W-1:0] w_tcnt_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_mem_err;
  logic                w_mem_err_nxt;
  logic                w_mem_load;

  // Datapath combinational nets
  logic [DATA_W-1:0]   w_sr1_val;
  logic [DATA_W-1:0]   w_sr2_val;
  logic [DATA_W-1:0]   w_alu_b;
  logic [DATA_W-1:0]   w_alu;
  logic [DATA_W-1:0]   w_eab_a;
  logic [DATA_W-1:0]   w_eab_off;
  logic [DATA_W-1:0]   w_eab;
  logic [DATA_W-1:0]   w_marm;
  logic [DATA_W-1:0]   w_bus;
  logic                w_contention;
  logic                w_busy;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_sr1_val = r_regs[sr1];
  assign w_sr2_val = r_regs[sr2];
  assign w_alu_b   = r_ir[5] ? {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]} : w_sr2_val;
  assign w_eab_a   = sel_eab1 ? w_sr1_val : r_pc;
  assign w_eab     = w_eab_a + w_eab_off;
  assign w_marm    = sel_mar ? {{(DATA_W-8){1'b0}}, r_ir[7:0]} : w_eab;

  // Two or more bus drivers in the same cycle
  assign w_contention = (ena_mdr & ena_pc)  | (ena_mdr & ena_alu) | (ena_mdr & ena_marm) |
                        (ena_pc  & ena_alu) | (ena_pc  & ena_marm) | (ena_alu & ena_marm);

  // ALU operation select; carry out of ADD is dropped
  always_comb begin
    w_alu = w_sr1_val;
    case (alu_ctrl)
      2'd0:    w_alu = w_sr1_val + w_alu_b;
      2'd1:    w_alu = w_sr1_val & w_alu_b;
      2'd2:    w_alu = ~w_sr1_val;
      default: w_alu = w_sr1_val;
    endcase
  end

  // EAB offset: sign-extended IR field chosen by sel_eab2
  always_comb begin
    w_eab_off = '0;
    case (sel_eab2)
      2'd0:    w_eab_off = '0;
      2'd1:    w_eab_off = {{(DATA_W-6){r_ir[5]}},   r_ir[5:0]};
      2'd2:    w_eab_off = {{(DATA_W-9){r_ir[8]}},   r_ir[8:0]};
      default: w_eab_off = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};
    endcase
  end

  // Internal bus: fixed-priority source mux, zero when undriven
  always_comb begin
    w_bus = '0;
    if (ena_mdr)       w_bus = r_mdr;
    else if (ena_pc)   w_bus = r_pc;
    else if (ena_alu)  w_bus = w_alu;
    else if (ena_marm) w_bus = w_marm;
  end

  // Register file write port; reads above see pre-edge contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (reg_we) begin
      r_regs[dr] <= w_bus;
    end
  end

  // PC, IR, MAR and condition codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_n   <= 1'b0;
      r_z   <= 1'b0;
      r_p   <= 1'b0;
    end else begin
      if (ld_pc) begin
        case (sel_pc)
          2'd0:    r_pc <= r_pc + DATA_W'(1);
          2'd1:    r_pc <= w_eab;
          2'd2:    r_pc <= w_bus;
          default: r_pc <= r_pc;
        endcase
      end
      if (ld_ir) r_ir <= w_bus;
      // Address must stay put while a transaction is outstanding
      if (ld_mar && !w_busy) r_mar <= w_bus;
      if (flag_we) begin
        r_n <= w_bus[DATA_W-1];
        r_z <= (w_bus == '0);
        r_p <= !w_bus[DATA_W-1] && (w_bus != '0);
      end
    end
  end

  // MDR: memory read data on completion, otherwise the bus when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdr <= '0;
    end else if (w_mem_load) begin
      r_mdr <= mem_rdata;
    end else if (ld_mdr && !w_busy) begin
      r_mdr <= w_bus;
    end
  end

  // Sticky bus-contention flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bus_err <= 1'b0;
    else if (w_contention) r_bus_err <= 1'b1;
  end

  // Memory FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_is_wr   <= 1'b0;
      r_tcnt    <= '0;
      r_done    <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_is_wr   <= w_is_wr_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_done    <= w_done_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  // Memory FSM next state: accept in IDLE (read wins), complete on ack,
  // abort on timeout; an ack on the timeout edge completes normally
  always_comb begin
    w_state_nxt   = r_state;
    w_is_wr_nxt   = r_is_wr;
    w_tcnt_nxt    = r_tcnt;
    w_done_nxt    = 1'b0;
    w_mem_err_nxt = r_mem_err;
    w_mem_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_rd || mem_wr) begin
          w_state_nxt = ST_BUSY;
          w_is_wr_nxt = !mem_rd;
          w_tcnt_nxt  = '0;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_mem_load  = !r_is_wr;
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_tcnt == C_TLAST) begin
          w_state_nxt   = ST_IDLE;
          w_done_nxt    = 1'b1;
          w_mem_err_nxt = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TCNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign mem_req   = w_busy;
  assign mem_busy  = w_busy;
  assign mem_we    = w_busy & r_is_wr;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign mem_done  = r_done;
  assign mem_err   = r_mem_err;
  assign bus_err   = r_bus_err;
  assign n         = r_n;
  assign z         = r_z;
  assign p         = r_p;
  assign ir        = r_ir;

endmodule
`default_nettype wire

// File: doc/lc3_datapath_gen.md
# lc3_datapath_gen

Parametrised next-generation LC-3 datapath: register file, PC, IR, MAR/MDR, ALU, effective-address adder and N/Z/P flags around a single tri-state-free internal bus. It generalises data width and register count. Its memory port is a req/ack handshake with a wait-state FSM and timeout, where the previous datapath had a combinational memory port. It also adds bus-contention detection. It sits between the LC-3 control FSM (which drives all enables/selects and stalls on `mem_busy`) and the memory model.

## Interface
- `DATA_W`, 16: datapath width; must be >= 16. IR fields use LC-3 bit positions in `ir[15:0]`.
- `NREG`, 8: register count, power of two; `RA_W = $clog2(NREG)`.
- `MEM_TIMEOUT`, 255: max BUSY cycles without `mem_ack` before abort; must be >= 1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena_mdr`, `ena_pc`, `ena_alu`, `ena_marm`  in  1 each  bus source enables
- `ld_pc`, `ld_ir`, `ld_mar`, `ld_mdr`, `reg_we`, `flag_we`  in  1 each  load enables
- `sel_mar`, `sel_eab1`  in  1 each  MARM / EAB operand-1 selects
- `sel_pc`, `sel_eab2`, `alu_ctrl`  in  2 each  PC source, EAB offset, ALU op
- `sr1`, `sr2`, `dr`  in  RA_W each  register addresses
- `mem_rd`, `mem_wr`  in  1 each  controller memory command (single-cycle pulse)
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write transaction
- `mem_addr`  out  DATA_W  equals MAR
- `mem_wdata`  out  DATA_W  equals MDR
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion
- `mem_busy`  out  1  transaction in flight
- `mem_done`  out  1  one-cycle completion pulse
- `mem_err`  out  1  sticky timeout flag
- `bus_err`  out  1  sticky contention flag
- `n`, `z`, `p`  out  1 each  condition codes
- `ir`  out  DATA_W  instruction register

## Operation
- Bus:
  - Priority mux MDR > PC > ALU > MARM.
  - No enable asserted: bus = 0.
  - Two or more enables in one cycle: `bus_err` sets at the next edge and stays set until reset.
- ALU, selected by `alu_ctrl`:
  - 0 ADD, 1 AND, 2 NOT SR1, 3 PASS SR1.
  - Operand 2 = `ir[5]` ? sext(`ir[4:0]`) : SR2.
  - Arithmetic is modulo 2^DATA_W; carry is discarded.
- EAB:
  - Operand 1 = `sel_eab1` ? SR1 : PC.
  - Operand 2 by `sel_eab2`: 0 → 0, 1 → sext(`ir[5:0]`), 2 → sext(`ir[8:0]`), 3 → sext(`ir[10:0]`).
  - Sum is modulo 2^DATA_W.
- MARM = `sel_mar` ? zext(`ir[7:0]`) : EAB.
- PC, when `ld_pc`, by `sel_pc`: 0 → PC+1 (wraps all-ones to 0), 1 → EAB, 2 → bus, 3 → hold.
- Register file:
  - Reads are combinational.
  - `reg_we` writes bus to `dr`.
  - Same-cycle read of `dr` returns the old value.
- Flags: with `flag_we`, bus is evaluated as signed DATA_W and exactly one of n/z/p becomes 1.
- Memory FSM, states IDLE and BUSY:
  - IDLE + `mem_rd` → BUSY, read.
  - IDLE + `mem_wr` → BUSY, write.
  - Both asserted together: read wins.
  - In BUSY: `mem_req` = 1 and `mem_we` = write.
  - Commands arriving in BUSY are ignored.
  - BUSY + `mem_ack`: for a read, MDR ← `mem_rdata`. Then → IDLE and pulse `mem_done`.
  - BUSY with no ack for MEM_TIMEOUT cycles: → IDLE, pulse `mem_done`, set `mem_err` (sticky). MDR is unchanged.
  - `mem_ack` in IDLE is ignored.
- Hazard guards:
  - `ld_mar` and `ld_mdr` are ignored while `mem_busy`, so address and data stay stable during a transaction.
  - `ld_mdr` loads MDR from the bus only.

## Timing
- Reset values: all registers, PC, IR, MAR and MDR = 0; n = z = p = 0; FSM in IDLE.
- Reset values of outputs: `mem_req`, `mem_we`, `mem_busy`, `mem_done`, `mem_err` and `bus_err` = 0.
- Reset is asynchronous and aborts any in-flight transaction immediately.
- Command latency:
  - `mem_rd` sampled at edge t → `mem_req` and `mem_busy` high from t+1.
  - `mem_ack` sampled high at edge k → MDR valid, `mem_done` = 1 and `mem_req` = 0 in cycle k+1.
  - Minimum command-to-done latency: 2 cycles.
- Timeout counter:
  - Clears on entering BUSY and increments each BUSY cycle without ack.
  - Abort occurs at the edge where the count reaches MEM_TIMEOUT.
  - An ack on that same edge wins: normal completion, no error.
- A new command may be issued in the cycle `mem_done` is high and is accepted.
- Register, PC, IR and flag updates are visible in the cycle after the load edge.

## Test plan
- Reset, then `ena_pc` with `ld_ir`: `ir` = 0 and all flags 0. Then `ld_pc` with `sel_pc` = 0 three times → PC = 3.
- Load R1 = 0x7FFF and run ADD with immediate 1 (`ir[5]` = 1, `ir[4:0]` = 1, `flag_we`) → bus = 0x8000 and n = 1. Then AND with imm 0 → z = 1.
- `mem_rd` with MAR = 0x3000, `mem_ack` after 3 wait cycles with `mem_rdata` = 0xBEEF → `mem_req` high for 4 cycles, `mem_done` pulses once, MDR = 0xBEEF. `ld_mar` attempted mid-transaction → MAR stays 0x3000.
- `mem_wr` with MTIMEOUT = 4 and no ack → `mem_req` drops after 4 cycles, `mem_done` pulses, `mem_err` = 1 and stays 1. MDR is unchanged.
- Assert `ena_pc` and `ena_alu` together with PC = 5 → bus = 5 and `bus_err` = 1 next cycle, held until `rst_n` low.
- DATA_W = 32, NREG = 16: write R15 = 0xFFFFFFFF, PC = 0xFFFFFFFF, `ld_pc` with `sel_pc` = 0 → PC = 0. PASS R15 with `flag_we` → n = 1.
